// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
//   Multicycle fetch/decode/sequence unit for the 16-bit datapath. It owns the
//   program counter and the instruction latch, fetches instruction words from
//   memory and drives every datapath enable/select through a fixed
//   FETCH -> DECODE -> EXEC [-> MEM] sequence. ALU flags are latched for
//   conditional branches.
//
//   Optional feature macro: CTRL_BRANCH_EN
//     defined   : Bcond (opcode 1100) is evaluated in EXEC against the latched
//                 flags; a taken branch loads pc <= (pc-1) + sext(imm).
//     undefined : Bcond decodes as a NOP, pc only changes in FETCH.
//
//   Ports
//     clk, reset          rising-edge clock, asynchronous active-high reset
//     mem_rdata/mem_ready memory read data / access completes this cycle
//     dp_adr              load/store data address from the datapath
//     C, L, F, Z, N       ALU flags from the datapath
//     mem_addr            memory address (pc in FETCH, dp_adr in MEM)
//     mem_rd / mem_wr     memory read / write request
//     instruction, pc     latched instruction word / program counter
//     aluControl          ALU op: ADD 0000 SUB 0001 AND 0010 OR 0011 XOR 0100 CMP 0101
//     srcRegEn, dstRegEn, immRegEn, signEn, regFileEn   datapath enables
//     shiftALUMuxEn, regImmMuxEn, mux4En, exMemResultEn datapath selects
//     flags               latched {C,L,F,Z,N}
//     o_dbg_state         current FSM state (0 FETCH, 1 DECODE, 2 EXEC, 3 MEM)
//
//   Memory handshake: a request (mem_rd or mem_wr) is held steady, together
//   with mem_addr, in every cycle of its state until mem_ready is sampled high;
//   the access completes in that cycle and the FSM advances on the same edge.
//   mem_rd and mem_wr are never asserted together.
// -----------------------------------------------------------------------------
module control_fsm #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] PC_RESET = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
   input  logic [WIDTH-1:0] dp_adr,
   input  logic             C,
   input  logic             L,
   input  logic             F,
   input  logic             Z,
   input  logic             N,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [WIDTH-1:0] instruction,
   output logic [WIDTH-1:0] pc,
   output logic [3:0]       aluControl,
   output logic             srcRegEn,
   output logic             dstRegEn,
   output logic             immRegEn,
   output logic             signEn,
   output logic             regFileEn,
   output logic             shiftALUMuxEn,
   output logic             regImmMuxEn,
   output logic [1:0]       mux4En,
   output logic [1:0]       exMemResultEn,
   output logic [4:0]       flags,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_MEM    = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_instr;
   logic [4:0]       r_flags;

   // ---------------------------------------------------------------- decode
   logic [3:0] w_op;
   logic [3:0] w_ext;
   logic [3:0] w_kind;
   logic       w_is_alu;
   logic       w_is_imm;
   logic       w_is_mov;
   logic       w_is_cmp;
   logic       w_flag_op;
   logic       w_is_lsh;
   logic       w_is_lshi;
   logic       w_is_load;
   logic       w_is_stor;
   logic       w_is_bcond;
   logic       w_sign_ext;
   logic [3:0] w_alu_ctl;

   assign w_op  = r_instr[15:12];
   assign w_ext = r_instr[7:4];

   // R-type ALU ops carry their operation in ext; immediate forms reuse the
   // same codes as the opcode, so one code space covers both.
   assign w_kind    = (w_op == 4'h0) ? w_ext : w_op;
   assign w_is_alu  = w_kind inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
   assign w_is_imm  = (w_op != 4'h0);
   assign w_is_mov  = w_is_alu && (w_kind == 4'hD);
   assign w_is_cmp  = w_is_alu && (w_kind == 4'hB);
   assign w_flag_op = w_is_alu && (w_kind inside {4'h5, 4'h9, 4'hB});
   assign w_is_lsh  = (w_op == 4'h8) && (w_ext == 4'h4);
   assign w_is_lshi = (w_op == 4'h8) && (w_ext[3:1] == 3'b000);
   assign w_is_load = (w_op == 4'h4) && (w_ext == 4'h0);
   assign w_is_stor = (w_op == 4'h4) && (w_ext == 4'h4);

`ifdef CTRL_BRANCH_EN
   logic             w_take;
   logic [WIDTH-1:0] w_br_target;

   assign w_is_bcond = (w_op == 4'hC);

   // Conditions test the flags latched by the last ADD/SUB/CMP-class op.
   always_comb begin
      w_take = 1'b0;
      case (r_instr[11:8])
         4'h0:    w_take =  r_flags[1];
         4'h1:    w_take = !r_flags[1];
         4'h2:    w_take =  r_flags[4];
         4'h3:    w_take = !r_flags[4];
         4'h6:    w_take =  r_flags[0];
         4'h7:    w_take = !r_flags[0];
         4'hE:    w_take = 1'b1;
         default: w_take = 1'b0;
      endcase
   end

   // pc already points past the branch, so step back one to make the offset
   // relative to the branch's own address.
   assign w_br_target = r_pc - PC_ONE + {{(WIDTH-8){r_instr[7]}}, r_instr[7:0]};
`else
   assign w_is_bcond = 1'b0;
`endif

   assign w_sign_ext = (w_is_alu && w_is_imm && (w_kind inside {4'h5, 4'h9, 4'hB, 4'hD}))
                       || w_is_lshi || w_is_bcond;

   always_comb begin
      w_alu_ctl = 4'b0000;
      case (w_kind)
         4'h5:    w_alu_ctl = 4'b0000;
         4'h9:    w_alu_ctl = 4'b0001;
         4'h1:    w_alu_ctl = 4'b0010;
         4'h2:    w_alu_ctl = 4'b0011;
         4'h3:    w_alu_ctl = 4'b0100;
         4'hB:    w_alu_ctl = 4'b0101;
         default: w_alu_ctl = 4'b0000;
      endcase
   end

   // --------------------------------------------------------- state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_state_nxt;
   end

   // ------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FETCH:  if (mem_ready) w_state_nxt = S_DECODE;
         S_DECODE: w_state_nxt = S_EXEC;
         S_EXEC:   w_state_nxt = (w_is_load || w_is_stor) ? S_MEM : S_FETCH;
         S_MEM:    if (mem_ready) w_state_nxt = S_FETCH;
         default:  w_state_nxt = S_FETCH;
      endcase
   end

   // ----------------------------------------------------- pc / instr / flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc    <= PC_RESET;
         r_instr <= '0;
         r_flags <= 5'b00000;
      end else begin
         if (r_state == S_FETCH && mem_ready) begin
            r_instr <= mem_rdata;
            r_pc    <= r_pc + PC_ONE;
         end
         if (r_state == S_EXEC && w_flag_op) r_flags <= {C, L, F, Z, N};
`ifdef CTRL_BRANCH_EN
         if (r_state == S_EXEC && w_is_bcond && w_take) r_pc <= w_br_target;
`endif
      end
   end

   // ---------------------------------------------------------------- outputs
   // Everything is forced low while reset is high so an aborted access drops
   // its request immediately, not at the next edge.
   always_comb begin
      mem_addr      = r_pc;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      aluControl    = 4'b0000;
      srcRegEn      = 1'b0;
      dstRegEn      = 1'b0;
      immRegEn      = 1'b0;
      signEn        = 1'b0;
      regFileEn     = 1'b0;
      shiftALUMuxEn = 1'b0;
      regImmMuxEn   = 1'b0;
      mux4En        = 2'b00;
      exMemResultEn = 2'b00;
      if (!reset) begin
         case (r_state)
            S_FETCH: mem_rd = 1'b1;
            S_DECODE: begin
               srcRegEn = 1'b1;
               dstRegEn = 1'b1;
               immRegEn = 1'b1;
               signEn   = w_sign_ext;
            end
            S_EXEC: begin
               if (w_is_alu) begin
                  aluControl = w_alu_ctl;
                  mux4En     = w_is_imm ? 2'b01 : 2'b00;
                  if (w_is_mov) begin
                     exMemResultEn = 2'b10;
                     regFileEn     = 1'b1;
                  end else if (!w_is_cmp) begin
                     regFileEn = 1'b1;
                  end
               end else if (w_is_lsh || w_is_lshi) begin
                  shiftALUMuxEn = 1'b1;
                  regImmMuxEn   = w_is_lshi;
                  regFileEn     = 1'b1;
               end
            end
            S_MEM: begin
               mem_addr = dp_adr;
               if (w_is_load) begin
                  mem_rd = 1'b1;
                  // Load data is written back in the completing cycle itself.
                  if (mem_ready) begin
                     exMemResultEn = 2'b01;
                     regFileEn     = 1'b1;
                  end
               end else if (w_is_stor) begin
                  mem_wr = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign instruction = r_instr;
   assign pc          = r_pc;
   assign flags       = r_flags;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_control_fsm
//   Directed bench for control_fsm. A small word memory answers fetches
//   combinationally; each task drives one scenario and checks the control
//   outputs with hand-computed expected values, sampling on the falling edge.
// -----------------------------------------------------------------------------
module tb_control_fsm;

   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_EXEC   = 2'd2;
   localparam logic [1:0] ST_MEM    = 2'd3;

   logic        clk;
   logic        reset;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic [15:0] dp_adr;
   logic        C, L, F, Z, N;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] instruction;
   logic [15:0] pc;
   logic [3:0]  aluControl;
   logic        srcRegEn, dstRegEn, immRegEn, signEn, regFileEn;
   logic        shiftALUMuxEn, regImmMuxEn;
   logic [1:0]  mux4En, exMemResultEn;
   logic [4:0]  flags;
   logic [1:0]  dbg_state;

   logic [15:0] mem [256];
   logic [14:0] ctl;

   int total;
   int bad;

   assign mem_rdata = mem[mem_addr[7:0]];
   // {src,dst,imm,sign,regFile,shift,regImm,mux4[1:0],exMem[1:0],alu[3:0]}
   assign ctl = {srcRegEn, dstRegEn, immRegEn, signEn, regFileEn, shiftALUMuxEn,
                 regImmMuxEn, mux4En, exMemResultEn, aluControl};

   control_fsm dut (
      .clk           (clk),
      .reset         (reset),
      .mem_rdata     (mem_rdata),
      .mem_ready     (mem_ready),
      .dp_adr        (dp_adr),
      .C             (C),
      .L             (L),
      .F             (F),
      .Z             (Z),
      .N             (N),
      .mem_addr      (mem_addr),
      .mem_rd        (mem_rd),
      .mem_wr        (mem_wr),
      .instruction   (instruction),
      .pc            (pc),
      .aluControl    (aluControl),
      .srcRegEn      (srcRegEn),
      .dstRegEn      (dstRegEn),
      .immRegEn      (immRegEn),
      .signEn        (signEn),
      .regFileEn     (regFileEn),
      .shiftALUMuxEn (shiftALUMuxEn),
      .regImmMuxEn   (regImmMuxEn),
      .mux4En        (mux4En),
      .exMemResultEn (exMemResultEn),
      .flags         (flags),
      .o_dbg_state   (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 256; i++) mem[i] = 16'h7000;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   // ADDI R1,#5 from word 0 after reset
   task automatic test_reset();
      mem_ready = 1'b1;
      {C, L, F, Z, N} = 5'b00000;
      dp_adr = 16'h0000;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({pc, instruction} !== 32'h0) begin
         bad++; $display("FAIL reset_pc_instr got=%h/%h exp=0000/0000", pc, instruction);
      end
      total++;
      if ({dbg_state, flags, mem_rd, mem_wr, ctl} !== 24'h0) begin
         bad++; $display("FAIL reset_outputs st=%0d flags=%b rd=%b wr=%b ctl=%h exp all 0",
                         dbg_state, flags, mem_rd, mem_wr, ctl);
      end
      reset = 1'b0;
      #1;
      total++;
      if (dbg_state !== ST_FETCH || mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
         bad++; $display("FAIL addi_fetch st=%0d rd=%b addr=%h exp 0/1/0000", dbg_state, mem_rd, mem_addr);
      end
      step();
      total++;
      if (dbg_state !== ST_DECODE || pc !== 16'h0001 || instruction !== 16'h5105) begin
         bad++; $display("FAIL addi_latch st=%0d pc=%h ins=%h exp 1/0001/5105", dbg_state, pc, instruction);
      end
      total++;
      if (ctl !== 15'h7800 || mem_rd !== 1'b0) begin
         bad++; $display("FAIL addi_decode ctl=%h rd=%b exp 7800/0", ctl, mem_rd);
      end
      step();
      total++;
      if (dbg_state !== ST_EXEC || ctl !== 15'h0440) begin
         bad++; $display("FAIL addi_exec st=%0d ctl=%h exp 2/0440", dbg_state, ctl);
      end
      step();
      total++;
      if (dbg_state !== ST_FETCH || pc !== 16'h0001 || mem_addr !== 16'h0001) begin
         bad++; $display("FAIL addi_back_fetch st=%0d pc=%h addr=%h exp 0/0001/0001", dbg_state, pc, mem_addr);
      end
   endtask

   // CMP R1,R2 (ext 1011) with Z=1: no write, Z latched
   task automatic test_cmp();
      int writes;
      writes = 0;
      {C, L, F, Z, N} = 5'b00010;
      step();
      if (regFileEn) writes++;
      total++;
      if (ctl !== 15'h7000) begin
         bad++; $display("FAIL cmp_decode ctl=%h exp 7000", ctl);
      end
      step();
      if (regFileEn) writes++;
      total++;
      if (dbg_state !== ST_EXEC || ctl !== 15'h0005) begin
         bad++; $display("FAIL cmp_exec st=%0d ctl=%h exp 2/0005", dbg_state, ctl);
      end
      step();
      total++;
      if (writes != 0) begin
         bad++; $display("FAIL cmp_no_write writes=%0d exp 0", writes);
      end
      total++;
      if (flags !== 5'b00010 || dbg_state !== ST_FETCH) begin
         bad++; $display("FAIL cmp_flags flags=%b st=%0d exp 00010/0", flags, dbg_state);
      end
      {C, L, F, Z, N} = 5'b00000;
   endtask

   // LOAD with 3 not-ready MEM cycles, then ready
   task automatic test_load();
      dp_adr = 16'h0123;
      step();
      step();
      mem_ready = 1'b0;
      step();
      for (int k = 0; k < 3; k++) begin
         total++;
         if (dbg_state !== ST_MEM || mem_addr !== 16'h0123 || mem_rd !== 1'b1 ||
             mem_wr !== 1'b0 || ctl !== 15'h0000) begin
            bad++; $display("FAIL load_wait%0d st=%0d addr=%h rd=%b wr=%b ctl=%h exp 3/0123/1/0/0000",
                            k, dbg_state, mem_addr, mem_rd, mem_wr, ctl);
         end
         step();
      end
      mem_ready = 1'b1;
      #1;
      total++;
      if (dbg_state !== ST_MEM || ctl !== 15'h0410 || mem_rd !== 1'b1) begin
         bad++; $display("FAIL load_ready st=%0d ctl=%h rd=%b exp 3/0410/1", dbg_state, ctl, mem_rd);
      end
      step();
      total++;
      if (dbg_state !== ST_FETCH || regFileEn !== 1'b0 || pc !== 16'h0003) begin
         bad++; $display("FAIL load_done st=%0d rf=%b pc=%h exp 0/0/0003", dbg_state, regFileEn, pc);
      end
   endtask

   // STOR: mem_wr only in MEM, held until ready, never a write-back
   task automatic test_stor();
      int rd_seen;
      int rf_seen;
      rd_seen = 0;
      rf_seen = 0;
      dp_adr = 16'h0456;
      step();
      if (mem_rd || mem_wr) rd_seen++;
      if (regFileEn) rf_seen++;
      step();
      if (mem_rd || mem_wr) rd_seen++;
      if (regFileEn) rf_seen++;
      mem_ready = 1'b0;
      step();
      for (int k = 0; k < 2; k++) begin
         if (regFileEn) rf_seen++;
         total++;
         if (dbg_state !== ST_MEM || mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 16'h0456) begin
            bad++; $display("FAIL stor_wait%0d st=%0d wr=%b rd=%b addr=%h exp 3/1/0/0456",
                            k, dbg_state, mem_wr, mem_rd, mem_addr);
         end
         step();
      end
      mem_ready = 1'b1;
      #1;
      if (regFileEn) rf_seen++;
      total++;
      if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin
         bad++; $display("FAIL stor_ready wr=%b rd=%b exp 1/0", mem_wr, mem_rd);
      end
      step();
      total++;
      if (dbg_state !== ST_FETCH || mem_wr !== 1'b0 || pc !== 16'h0004) begin
         bad++; $display("FAIL stor_done st=%0d wr=%b pc=%h exp 0/0/0004", dbg_state, mem_wr, pc);
      end
      total++;
      if (rd_seen != 0 || rf_seen != 0) begin
         bad++; $display("FAIL stor_no_rd_rf rd_or_wr_early=%0d rf=%0d exp 0/0", rd_seen, rf_seen);
      end
   endtask

   // back-to-back mix of immediate, shift, register and NOP instructions
   task automatic test_back_to_back();
      logic [15:0] op  [7];
      logic [14:0] dec [7];
      logic [14:0] exe [7];
      logic [14:0] msk [7];
      logic [4:0]  flg [7];
      op  = '{16'hD105, 16'h8101, 16'h8142, 16'h1105, 16'h0132, 16'h9105, 16'h7000};
      dec = '{15'h7800, 15'h7800, 15'h7000, 15'h7000, 15'h7000, 15'h7800, 15'h7000};
      exe = '{15'h0460, 15'h0700, 15'h0600, 15'h0442, 15'h0404, 15'h0441, 15'h0000};
      msk = '{15'h7FF0, 15'h7FF0, 15'h7FF0, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FF0};
      flg = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b10101, 5'b10101};
      fill_nop();
      for (int i = 0; i < 7; i++) mem[i] = op[i];
      mem_ready = 1'b1;
      {C, L, F, Z, N} = 5'b10101;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         total++;
         if (dbg_state !== ST_FETCH || mem_addr !== 16'(i)) begin
            bad++; $display("FAIL b2b_fetch%0d st=%0d addr=%h exp 0/%h", i, dbg_state, mem_addr, 16'(i));
         end
         step();
         total++;
         if (ctl !== dec[i]) begin
            bad++; $display("FAIL b2b_decode%0d ins=%h ctl=%h exp %h", i, op[i], ctl, dec[i]);
         end
         step();
         total++;
         if ((ctl & msk[i]) !== exe[i]) begin
            bad++; $display("FAIL b2b_exec%0d ins=%h ctl=%h exp %h", i, op[i], ctl & msk[i], exe[i]);
         end
         step();
         total++;
         if (flags !== flg[i]) begin
            bad++; $display("FAIL b2b_flags%0d ins=%h flags=%b exp %b", i, op[i], flags, flg[i]);
         end
      end
      {C, L, F, Z, N} = 5'b00000;
   endtask

   // CMP at 9 sets Z, Bcond EQ imm=FE at 10
   task automatic test_branch(input logic z_val, input logic [15:0] exp_pc, input logic exp_sign);
      int writes;
      writes = 0;
      fill_nop();
      mem[9]  = 16'h01B2;
      mem[10] = 16'hC0FE;
      mem_ready = 1'b1;
      {C, L, F, Z, N} = {3'b000, z_val, 1'b0};
      do_reset();
      for (int k = 0; k < 30; k++) begin
         step();
         if (regFileEn) writes++;
      end
      total++;
      if (dbg_state !== ST_FETCH || pc !== 16'd10 || flags !== {3'b000, z_val, 1'b0} || writes != 0) begin
         bad++; $display("FAIL br_setup_z%0d st=%0d pc=%h flags=%b writes=%0d exp 0/000a/%b/0",
                         z_val, dbg_state, pc, flags, writes, {3'b000, z_val, 1'b0});
      end
      step();
      total++;
      if (signEn !== exp_sign) begin
         bad++; $display("FAIL br_sign_z%0d signEn=%b exp %b", z_val, signEn, exp_sign);
      end
      step();
      step();
      total++;
      if (dbg_state !== ST_FETCH || pc !== exp_pc || regFileEn !== 1'b0) begin
         bad++; $display("FAIL br_pc_z%0d st=%0d pc=%h exp 0/%h", z_val, dbg_state, pc, exp_pc);
      end
      {C, L, F, Z, N} = 5'b00000;
   endtask

   // reset in the middle of a LOAD's MEM state
   task automatic test_reset_mid_load();
      fill_nop();
      mem[0] = 16'h4203;
      mem_ready = 1'b1;
      dp_adr = 16'h0040;
      do_reset();
      step();
      step();
      mem_ready = 1'b0;
      step();
      total++;
      if (dbg_state !== ST_MEM || mem_rd !== 1'b1 || mem_addr !== 16'h0040 || pc !== 16'h0001) begin
         bad++; $display("FAIL abort_pre st=%0d rd=%b addr=%h pc=%h exp 3/1/0040/0001",
                         dbg_state, mem_rd, mem_addr, pc);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || ctl !== 15'h0000 || pc !== 16'h0000 || dbg_state !== ST_FETCH) begin
         bad++; $display("FAIL abort_async rd=%b wr=%b ctl=%h pc=%h st=%0d exp 0/0/0000/0000/0",
                         mem_rd, mem_wr, ctl, pc, dbg_state);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      total++;
      if (regFileEn !== 1'b0 || mem_rd !== 1'b0) begin
         bad++; $display("FAIL abort_hold rf=%b rd=%b exp 0/0", regFileEn, mem_rd);
      end
      reset = 1'b0;
      #1;
      total++;
      if (dbg_state !== ST_FETCH || mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
         bad++; $display("FAIL abort_release st=%0d rd=%b addr=%h exp 0/1/0000", dbg_state, mem_rd, mem_addr);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      fill_nop();
      mem[0] = 16'h5105;
      mem[1] = 16'h01B2;
      mem[2] = 16'h4203;
      mem[3] = 16'h4443;
      test_reset();
      test_cmp();
      test_load();
      test_stor();
      test_back_to_back();
`ifdef CTRL_BRANCH_EN
      test_branch(1'b1, 16'd8, 1'b1);
      test_branch(1'b0, 16'd11, 1'b1);
`else
      test_branch(1'b1, 16'd11, 1'b0);
      test_branch(1'b0, 16'd11, 1'b0);
`endif
      test_reset_mid_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
